// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider beside the EX-stage ALU.
// Define MDU_DIV_EN to build the divider; without it, divide/remainder ops return 0 in one cycle.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            kill_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);
  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic              neg_q, neg_d;
  logic              hi_q, hi_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              s1_neg, s2_neg;
  logic [XLEN-1:0]   mag1, mag2;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] step_acc, prod_s;
  logic [XLEN-1:0]   final_res;

`ifdef MDU_DIV_EN
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic              div_q, div_d;
  logic              rem_q, rem_d;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   fast_res, quo_s, rem_s;
  logic [XLEN:0]     rem_shift;
  logic [XLEN-1:0]   rem_new;
  logic              rem_ge;
`endif

  // Operand decode: signed operands become magnitudes at accept.
  always_comb begin
    s1_neg = src1_i[XLEN-1] & (op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11));
    s2_neg = src2_i[XLEN-1] & (op_i[2] ? ~op_i[0] : ~op_i[1]);
    mag1   = s1_neg ? -src1_i : src1_i;
    mag2   = s2_neg ? -src2_i : src2_i;
`ifdef MDU_DIV_EN
    div_zero = (src2_i == '0);
    div_ovf  = ~op_i[0] && (src1_i == MIN_NEG) && (src2_i == '1);
    if (div_zero) fast_res = op_i[1] ? src1_i : '1;
    else          fast_res = op_i[1] ? '0 : src1_i;
`endif
  end

  // One iteration of the shared accumulator plus the sign-corrected final result.
  // The last iteration and the sign fix happen on the edge into DONE so result_o is valid there.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    step_acc = {mul_sum, acc_q[XLEN-1:1]};
`ifdef MDU_DIV_EN
    rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_ge    = (rem_shift >= {1'b0, opa_q});
    rem_new   = rem_ge ? XLEN'(rem_shift - {1'b0, opa_q}) : rem_shift[XLEN-1:0];
    if (div_q) step_acc = {rem_new, acc_q[XLEN-2:0], rem_ge};
    quo_s = neg_q ? -step_acc[XLEN-1:0] : step_acc[XLEN-1:0];
    rem_s = neg_q ? -step_acc[2*XLEN-1:XLEN] : step_acc[2*XLEN-1:XLEN];
`endif
    prod_s    = neg_q ? -step_acc : step_acc;
    final_res = hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
`ifdef MDU_DIV_EN
    if (div_q) final_res = rem_q ? rem_s : quo_s;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    result_d = result_q;
`ifdef MDU_DIV_EN
    div_d    = div_q;
    rem_d    = rem_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !kill_i) begin
          cnt_d = '0;
          hi_d  = (op_i[1:0] != 2'b00);
          neg_d = (op_i[2] & op_i[1]) ? s1_neg : (s1_neg ^ s2_neg);
          if (op_i[2]) begin
`ifdef MDU_DIV_EN
            div_d = 1'b1;
            rem_d = op_i[1];
            acc_d = {{XLEN{1'b0}}, mag1};
            opa_d = mag2;
            if (div_zero || div_ovf) begin
              result_d = fast_res;
              state_d  = S_DONE;
            end else begin
              state_d  = S_CALC;
            end
`else
            result_d = '0;
            state_d  = S_DONE;
`endif
          end else begin
`ifdef MDU_DIV_EN
            div_d = 1'b0;
            rem_d = 1'b0;
`endif
            acc_d   = {{XLEN{1'b0}}, mag2};
            opa_d   = mag1;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN-1)) begin
          result_d = final_res;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (kill_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      neg_q    <= 1'b0;
      hi_q     <= 1'b0;
      result_q <= '0;
`ifdef MDU_DIV_EN
      div_q    <= 1'b0;
      rem_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      result_q <= result_d;
`ifdef MDU_DIV_EN
      div_q    <= div_d;
      rem_q    <= rem_d;
`endif
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign valid_o  = (state_q == S_DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit (XLEN=32); divide checks follow the MDU_DIV_EN build option.
module tb_muldiv_unit;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            kill;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            valid;
  logic [XLEN-1:0] result;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .kill_i   (kill),
    .op_i     (op),
    .src1_i   (a),
    .src2_i   (b),
    .busy_o   (busy),
    .valid_o  (valid),
    .result_o (result)
  );

  // Issue one op, scramble inputs after accept, and watch until busy drops (bounded).
  task automatic run_op(input logic [2:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                        output logic [XLEN-1:0] res, output int vcyc, output int blow, output int nvalid);
    int cyc;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = ~o; a = ~x; b = ~y;
    cyc = 1; vcyc = -1; blow = -1; nvalid = 0; res = 'x;
    while (cyc <= 80) begin
      if (valid) begin
        nvalid++;
        vcyc = cyc;
        res  = result;
      end
      if (!busy) begin
        blow = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    vectors++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid); end
    vectors++;
    if (result !== '0) begin errors++; $display("FAIL reset_result got=%h want=0", result); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [XLEN-1:0] r;
    int v, bl, nv;
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, r, v, bl, nv);
    vectors++;
    if (r !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_result got=%h want=ffffffeb", r); end
    vectors++;
    if (v !== 33) begin errors++; $display("FAIL mul_valid_cycle got=%0d want=33", v); end
    vectors++;
    if (bl !== 34) begin errors++; $display("FAIL mul_busy_low_cycle got=%0d want=34", bl); end
    vectors++;
    if (nv !== 1) begin errors++; $display("FAIL mul_valid_pulses got=%0d want=1", nv); end
    repeat (3) @(negedge clk);
    vectors++;
    if (result !== 32'hFFFFFFEB) begin errors++; $display("FAIL mul_result_hold got=%h want=ffffffeb", result); end
  endtask

  task automatic test_mul_high();
    logic [2:0]      ops [4];
    logic [XLEN-1:0] xs  [4];
    logic [XLEN-1:0] ys  [4];
    logic [XLEN-1:0] exp [4];
    logic [XLEN-1:0] r;
    int v, bl, nv;
    ops = '{3'b001, 3'b011, 3'b010, 3'b001};
    xs  = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    ys  = '{32'h80000000, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF};
    exp = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], xs[i], ys[i], r, v, bl, nv);
      vectors++;
      if (r !== exp[i]) begin errors++; $display("FAIL mulh[%0d] got=%h want=%h", i, r, exp[i]); end
      vectors++;
      if (v !== 33) begin errors++; $display("FAIL mulh[%0d]_valid_cycle got=%0d want=33", i, v); end
    end
  endtask

`ifdef MDU_DIV_EN
  task automatic test_div();
    logic [2:0]      ops [4];
    logic [XLEN-1:0] xs  [4];
    logic [XLEN-1:0] ys  [4];
    logic [XLEN-1:0] exp [4];
    logic [XLEN-1:0] r;
    int v, bl, nv;
    ops = '{3'b100, 3'b110, 3'b101, 3'b111};
    xs  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    ys  = '{32'd2, 32'd2, 32'd7, 32'd7};
    exp = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], xs[i], ys[i], r, v, bl, nv);
      vectors++;
      if (r !== exp[i]) begin errors++; $display("FAIL div[%0d] got=%h want=%h", i, r, exp[i]); end
      vectors++;
      if (v !== 33 || bl !== 34) begin
        errors++; $display("FAIL div[%0d]_timing valid=%0d busy_low=%0d want=33/34", i, v, bl);
      end
    end
  endtask

  task automatic test_special();
    logic [2:0]      ops [5];
    logic [XLEN-1:0] xs  [5];
    logic [XLEN-1:0] ys  [5];
    logic [XLEN-1:0] exp [5];
    logic [XLEN-1:0] r;
    int v, bl, nv;
    ops = '{3'b101, 3'b110, 3'b100, 3'b110, 3'b100};
    xs  = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd5};
    ys  = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
    exp = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF};
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], xs[i], ys[i], r, v, bl, nv);
      vectors++;
      if (r !== exp[i]) begin errors++; $display("FAIL special[%0d] got=%h want=%h", i, r, exp[i]); end
      vectors++;
      if (v !== 1 || bl !== 2) begin
        errors++; $display("FAIL special[%0d]_timing valid=%0d busy_low=%0d want=1/2", i, v, bl);
      end
    end
  endtask
`else
  task automatic test_no_div();
    logic [2:0]      ops [2];
    logic [XLEN-1:0] xs  [2];
    logic [XLEN-1:0] ys  [2];
    logic [XLEN-1:0] r;
    int v, bl, nv;
    ops = '{3'b100, 3'b111};
    xs  = '{32'd9, 32'd7};
    ys  = '{32'd3, 32'd0};
    for (int i = 0; i < 2; i++) begin
      run_op(ops[i], xs[i], ys[i], r, v, bl, nv);
      vectors++;
      if (r !== '0) begin errors++; $display("FAIL nodiv[%0d] got=%h want=0", i, r); end
      vectors++;
      if (v !== 1 || bl !== 2) begin
        errors++; $display("FAIL nodiv[%0d]_timing valid=%0d busy_low=%0d want=1/2", i, v, bl);
      end
    end
  endtask
`endif

  task automatic test_kill_back_to_back();
    logic [XLEN-1:0] r;
    int v, bl, nv, cyc, nval;
    run_op(3'b000, 32'd5, 32'd6, r, v, bl, nv);
    vectors++;
    if (r !== 32'd30) begin errors++; $display("FAIL kill_pre_result got=%h want=1e", r); end
    @(negedge clk);
    op = 3'b000; a = 32'h1234; b = 32'h10; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; cyc = 1; nval = 0;
    while (cyc < 10) begin
      if (valid) nval++;
      if (cyc == 3) begin
        start = 1'b1; op = 3'b000; a = 32'd100; b = 32'd100;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    if (valid) nval++;
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin errors++; $display("FAIL kill_busy got=%b want=0", busy); end
    vectors++;
    if (nval !== 0 || valid !== 1'b0) begin
      errors++; $display("FAIL kill_valid pulses=%0d valid=%b want=0/0", nval, valid);
    end
    vectors++;
    if (result !== 32'd30) begin errors++; $display("FAIL kill_result_kept got=%h want=1e", result); end
    op = 3'b000; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; cyc = 12; v = -1; bl = -1; nval = 0;
    while (cyc <= 90) begin
      if (valid) begin nval++; v = cyc; r = result; end
      if (!busy) begin bl = cyc; break; end
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (v !== 44) begin errors++; $display("FAIL b2b_valid_cycle got=%0d want=44", v); end
    vectors++;
    if (r !== 32'd12) begin errors++; $display("FAIL b2b_result got=%h want=c", r); end
    vectors++;
    if (bl !== 45 || nval !== 1) begin
      errors++; $display("FAIL b2b_idle busy_low=%0d pulses=%0d want=45/1", bl, nval);
    end
  endtask

  task automatic test_kill_done();
    int cyc, v;
    @(negedge clk);
    op = 3'b000; a = 32'h100; b = 32'h100; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; cyc = 1; v = -1;
    while (cyc <= 40 && v < 0) begin
      if (valid) v = cyc;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    vectors++;
    if (v !== 33) begin errors++; $display("FAIL killdone_valid_cycle got=%0d want=33", v); end
    kill = 1'b1;
    #1;
    vectors++;
    if (valid !== 1'b1) begin errors++; $display("FAIL killdone_valid_held got=%b want=1", valid); end
    @(negedge clk);
    start = 1'b1; op = 3'b000; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL kill_start_idle busy=%b valid=%b want=0/0", busy, valid);
    end
    vectors++;
    if (result !== 32'h10000) begin errors++; $display("FAIL killdone_result got=%h want=10000", result); end
  endtask

  task automatic test_reset_mid();
    int nval;
    @(negedge clk);
`ifdef MDU_DIV_EN
    op = 3'b101; a = 32'd100; b = 32'd7;
`else
    op = 3'b000; a = 32'd3; b = 32'd4;
`endif
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_ctrl busy=%b valid=%b want=0/0", busy, valid);
    end
    vectors++;
    if (result !== '0) begin errors++; $display("FAIL rstmid_result got=%h want=0", result); end
    @(negedge clk);
    rst = 1'b0;
    nval = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid || busy) nval++;
    end
    vectors++;
    if (nval !== 0) begin errors++; $display("FAIL rstmid_after activity_cycles=%0d want=0", nval); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
    test_reset();
    test_mul();
    test_mul_high();
`ifdef MDU_DIV_EN
    test_div();
    test_special();
`else
    test_no_div();
`endif
    test_kill_back_to_back();
    test_kill_done();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
